code_burst_gen: RTL and testbench

Moore-style generator that drives a 4-bit code bus with a programmable-length run of a key code word, followed by a guaranteed non-key gap cycle. It is the transmit-side counterpart of the team's consecutive-key-code detectors. It produces the stimulus those detectors qualify on: a run of N back-to-back key words, then a non-key word. It sits between a controller that requests bursts via a start/done handshake and the shared code bus.

---
 rtl/code_burst_gen.sv | 104 ++++++++++
 tb/tb_code_burst_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/code_burst_gen.sv
// Burst generator for the shared 4-bit code bus: emits len KEY words, one non-key gap word, then a done pulse.
// Optional abort support (abort/aborted ports) is compiled in with `define CODE_BURST_GEN_ABORT_EN.
module code_burst_gen #(
   parameter logic [3:0] KEY       = 4'b1101,
   parameter logic [3:0] IDLE_CODE = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] len,
`ifdef CODE_BURST_GEN_ABORT_EN
   input  logic       abort,
   output logic       aborted,
`endif
   output logic [3:0] code_out,
   output logic       busy,
   output logic       done
);

   // state | meaning
   // IDLE  | bus at IDLE_CODE, waiting for start
   // BURST | driving KEY, counter holds remaining KEY cycles
   // GAP   | one forced non-key word so the detector drops back to zero
   // DONE  | one-cycle done pulse; start accepted here as in IDLE
   localparam logic [2:0] S_IDLE  = 3'b000;
   localparam logic [2:0] S_BURST = 3'b001;
   localparam logic [2:0] S_GAP   = 3'b010;
   localparam logic [2:0] S_DONE  = 3'b100;

   logic [2:0] state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       abort_req;

`ifdef CODE_BURST_GEN_ABORT_EN
   logic abort_seen;

   assign abort_req = abort;

   // abort_seen survives the GAP cycle so that DONE can report it
   always_ff @(posedge clk) begin
      if (reset) begin
         abort_seen <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         if (state == S_BURST)
            abort_seen <= abort;
         else if (state != S_GAP)
            abort_seen <= 1'b0;
         aborted <= (state == S_GAP) && abort_seen;
      end
   end
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      state_nxt = S_IDLE;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (len != 4'd0) begin
                  state_nxt = S_BURST;
                  cnt_nxt   = len;
               end else begin
                  state_nxt = S_DONE;
                  cnt_nxt   = 4'd0;
               end
            end
         end
         S_BURST: begin
            if (abort_req || (cnt == 4'd1)) begin
               state_nxt = S_GAP;
            end else begin
               state_nxt = S_BURST;
               cnt_nxt   = cnt - 4'd1;
            end
         end
         S_GAP: state_nxt = S_DONE;
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // outputs are registered from the next state so they line up with state
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         code_out <= IDLE_CODE;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         code_out <= (state_nxt == S_BURST) ? KEY : IDLE_CODE;
         busy     <= (state_nxt == S_BURST) || (state_nxt == S_GAP);
         done     <= (state_nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_code_burst_gen.sv
// Scoreboard bench for code_burst_gen: a frame-schedule model predicts every output cycle.
// Builds with or without CODE_BURST_GEN_ABORT_EN.
module tb_code_burst_gen;

   localparam logic [3:0] KEY       = 4'b1101;
   localparam logic [3:0] IDLE_CODE = 4'b0000;
`ifdef CODE_BURST_GEN_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] code;
      logic       busy;
      logic       done;
      logic       aborted;
   } frame_t;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       start    = 1'b0;
   logic       abort_in = 1'b0;
   logic [3:0] len      = 4'd0;
   logic [3:0] code_out;
   logic       busy, done, aborted_act;

   code_burst_gen #(.KEY(KEY), .IDLE_CODE(IDLE_CODE)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .len      (len),
`ifdef CODE_BURST_GEN_ABORT_EN
      .abort    (abort_in),
      .aborted  (aborted_act),
`endif
      .code_out (code_out),
      .busy     (busy),
      .done     (done)
   );

`ifndef CODE_BURST_GEN_ABORT_EN
   assign aborted_act = 1'b0;
`endif

   always #5 clk = ~clk;

   frame_t plan[$];
   frame_t exp_q[$];
   frame_t cur;
   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;

   function automatic frame_t mk(input logic [3:0] c, input logic b, input logic d, input logic a);
      frame_t f;
      f.code = c; f.busy = b; f.done = d; f.aborted = a;
      return f;
   endfunction

   // Model: an accepted start schedules the whole burst as a list of future frames.
   task automatic step(input logic s, input logic [3:0] l, input logic a, input logic r);
      frame_t nxt;
      @(negedge clk);
      start = s; len = l; abort_in = a; reset = r;
      if (reset) begin
         plan.delete();
         nxt = mk(IDLE_CODE, 1'b0, 1'b0, 1'b0);
      end else begin
         if (!cur.busy && start) begin
            plan.delete();
            for (int i = 0; i < int'(len); i++) plan.push_back(mk(KEY, 1'b1, 1'b0, 1'b0));
            if (len != 4'd0) plan.push_back(mk(IDLE_CODE, 1'b1, 1'b0, 1'b0));
            plan.push_back(mk(IDLE_CODE, 1'b0, 1'b1, 1'b0));
         end else if (ABORT_EN && abort_in && cur.code == KEY) begin
            plan.delete();
            plan.push_back(mk(IDLE_CODE, 1'b1, 1'b0, 1'b0));
            plan.push_back(mk(IDLE_CODE, 1'b0, 1'b1, 1'b1));
         end
         nxt = (plan.size() > 0) ? plan.pop_front() : mk(IDLE_CODE, 1'b0, 1'b0, 1'b0);
      end
      cur = nxt;
      exp_q.push_back(nxt);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   // monitor: each expected frame is checked one edge after it was scheduled
   initial begin
      frame_t e, act;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = mk(code_out, busy, done, aborted_act);
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL frame cyc=%0d actual code=%b busy=%b done=%b aborted=%b required code=%b busy=%b done=%b aborted=%b",
                        cyc, act.code, act.busy, act.done, act.aborted, e.code, e.busy, e.done, e.aborted);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       rs, ss, aa;
      logic [3:0] ll;
      cur = mk(IDLE_CODE, 1'b0, 1'b0, 1'b0);

      step(1'b0, 4'd0, 1'b0, 1'b1);
      step(1'b0, 4'd0, 1'b0, 1'b1);
      idle(3);
      step(1'b1, 4'd3, 1'b0, 1'b0);   idle(7);
      step(1'b1, 4'd0, 1'b0, 1'b0);   idle(3);
      step(1'b1, 4'd1, 1'b0, 1'b0);   idle(4);
      for (int i = 0; i < 12; i++) step(1'b1, 4'd2, 1'b0, 1'b0);
      idle(2);
      step(1'b1, 4'd5, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 4'd9, 1'b0, 1'b0);
      idle(4);
      step(1'b1, 4'd15, 1'b0, 1'b0);  idle(19);
      step(1'b1, 4'd10, 1'b0, 1'b0);  idle(3);
      step(1'b0, 4'd0, 1'b0, 1'b1);
      step(1'b1, 4'd2, 1'b0, 1'b0);   idle(5);
      step(1'b1, 4'd8, 1'b0, 1'b0);   idle(2);
      step(1'b0, 4'd0, 1'b1, 1'b0);   idle(4);
      step(1'b1, 4'd3, 1'b0, 1'b0);   idle(1);
      step(1'b0, 4'd0, 1'b1, 1'b0);   idle(1);
      step(1'b0, 4'd0, 1'b1, 1'b0);   idle(3);

      for (int i = 0; i < 2000; i++) begin
         rs = ($urandom_range(0, 79) == 0);
         ss = ($urandom_range(0, 3) == 0);
         aa = ($urandom_range(0, 11) == 0);
         ll = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         step(ss, ll, aa, rs);
      end
      idle(20);

      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
